// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a length/data/checksum byte frame into RAM via the MAR while the CPU is held
// The CPU is released through a cpu_rst pulse only after the checksum matches.
module program_loader #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int RESET_PULSE    = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  cpu_halt,
  output logic                  cpu_rst,
  output logic                  mar_load,
  output logic [ADDR_WIDTH-1:0] mar_addr,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code
);
  localparam int CW      = ADDR_WIDTH + 1;
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW      = $clog2(RESET_PULSE + 1);
  localparam int MAX_LEN = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_ADDR, S_WRITE, S_CHECK, S_RELEASE, S_ERROR
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] sum;
  logic [TW-1:0]         timer;
  logic [PW-1:0]         pulse;
  logic                  accept, timed_out, len_bad, done_n;
  logic [1:0]            code_n;

  always_comb begin
    accept    = in_valid && in_ready;
    len_bad   = (in_data == '0) || (int'(in_data) > MAX_LEN);
    // An accept on the limit cycle takes priority over the timeout.
    timed_out = !accept && (timer == TW'(TIMEOUT_CYCLES - 1));
    state_n   = state;
    code_n    = error_code;
    done_n    = done;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_n = S_LEN;
          code_n  = 2'b00;
          done_n  = 1'b0;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_n = S_ERROR;
            code_n  = 2'b01;
          end else begin
            state_n = S_DATA;
          end
        end else if (timed_out) begin
          state_n = S_ERROR;
          code_n  = 2'b11;
        end
      end
      S_DATA: begin
        if (accept) begin
          state_n = S_ADDR;
        end else if (timed_out) begin
          state_n = S_ERROR;
          code_n  = 2'b11;
        end
      end
      S_ADDR:  state_n = S_WRITE;
      S_WRITE: state_n = (count == CW'(1)) ? S_CHECK : S_DATA;
      S_CHECK: begin
        if (accept) begin
          if (in_data == sum) begin
            state_n = S_RELEASE;
          end else begin
            state_n = S_ERROR;
            code_n  = 2'b10;
          end
        end else if (timed_out) begin
          state_n = S_ERROR;
          code_n  = 2'b11;
        end
      end
      S_RELEASE: begin
        if (pulse == PW'(RESET_PULSE - 1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      addr       <= '0;
      sum        <= '0;
      timer      <= '0;
      pulse      <= '0;
      in_ready   <= 1'b0;
      cpu_halt   <= 1'b0;
      cpu_rst    <= 1'b0;
      mar_load   <= 1'b0;
      mar_addr   <= '0;
      ram_write  <= 1'b0;
      ram_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      error_code <= 2'b00;
    end else begin
      state      <= state_n;
      done       <= done_n;
      error_code <= code_n;
      in_ready   <= (state_n == S_LEN) || (state_n == S_DATA) || (state_n == S_CHECK);
      mar_load   <= (state_n == S_ADDR);
      ram_write  <= (state_n == S_WRITE);
      cpu_rst    <= (state_n == S_RELEASE);
      cpu_halt   <= (state_n != S_IDLE);
      busy       <= (state_n != S_IDLE) && (state_n != S_ERROR);
      error      <= (state_n == S_ERROR);

      if (state == S_IDLE || state == S_ERROR) begin
        timer <= '0;
      end else if (state == S_LEN || state == S_DATA || state == S_CHECK) begin
        timer <= accept ? '0 : timer + TW'(1);
      end

      pulse <= (state == S_RELEASE) ? pulse + PW'(1) : '0;

      if ((state == S_IDLE || state == S_ERROR) && start) begin
        addr <= '0;
        sum  <= '0;
      end
      if (state == S_LEN && accept) begin
        count <= CW'(in_data);
      end
      if (state == S_DATA && accept) begin
        ram_data <= in_data;
        sum      <= sum + in_data;
      end
      if (state_n == S_ADDR) begin
        mar_addr <= addr;
      end
      // Final increment may wrap to zero; nothing reads addr afterwards.
      if (state == S_WRITE) begin
        addr  <= addr + ADDR_WIDTH'(1);
        count <= count - CW'(1);
      end
    end
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sequences the MAR and RAM to load a program from a byte stream (UART receiver or similar) while the CPU is held, then restarts the CPU.
- Sits alongside the CPU top: drives MAR address/load and RAM write/data in manual-programming style, asserts the clock halt, and pulses CPU reset on completion.
- Frame format: length byte L, then L data bytes written to addresses 0..L-1, then one checksum byte equal to the 8-bit sum of the data bytes.

Parameters:
ADDR_WIDTH, 4, MAR/RAM address width; legal length is 1..2^ADDR_WIDTH
DATA_WIDTH, 8, byte and RAM word width
RESET_PULSE, 4, cycles cpu_rst is held high after a successful load (>=1)
TIMEOUT_CYCLES, 1000000, idle cycles allowed while waiting for a byte before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  begin a load; sampled only in IDLE
in_valid  in  1  stream byte valid
in_ready  out  1  loader accepts byte this cycle
in_data  in  DATA_WIDTH  stream byte
cpu_halt  out  1  hold CPU clock
cpu_rst  out  1  CPU reset pulse
mar_load  out  1  MAR latches mar_addr this cycle
mar_addr  out  ADDR_WIDTH  target address
ram_write  out  1  RAM writes ram_data at latched address this cycle
ram_data  out  DATA_WIDTH  word to write
busy  out  1  load in progress
done  out  1  sticky: last load succeeded
error  out  1  sticky: last load failed
error_code  out  2  00 none, 01 bad length, 10 checksum mismatch, 11 timeout

Behaviour:
- One clock (clk), reset asynchronous and active-high (rst).
- Reset: state IDLE; all outputs 0; error_code 00; internal count, address, sum and timer cleared. Mid-operation reset aborts immediately. RAM contents already written stay as they are.
- All outputs are registered or decoded from the state register. in_ready is 1 exactly in LEN, DATA and CHECK.
- A byte is accepted on a cycle with in_valid & in_ready. in_valid while in_ready=0 is ignored and the byte is not consumed.
- IDLE: start=1 -> LEN. Next cycle: cpu_halt=1, busy=1, done=0, error=0, error_code=00, addr=0, sum=0, timer=0. start while busy is ignored.
- LEN: on accept, L=in_data.
  - L==0 or L>2^ADDR_WIDTH -> ERROR, code 01.
  - Otherwise count=L -> DATA.
- DATA: on accept, ram_data<=in_data, sum<=sum+in_data mod 2^DATA_WIDTH -> ADDR.
- ADDR: one cycle, mar_load=1, mar_addr=addr -> WRITE.
- WRITE: one cycle, ram_write=1; mar_addr and ram_data held stable. Then addr<=addr+1 and count<=count-1.
  - count becomes 0 -> CHECK.
  - Otherwise -> DATA.
- Latency: data byte accept to ram_write is 2 cycles. Minimum 3 cycles per byte.
- Address never wraps: L=2^ADDR_WIDTH ends at the top address. The addr increment after the final write is don't-care.
- CHECK: on accept:
  - in_data==sum -> RELEASE.
  - Otherwise -> ERROR, code 10.
- RELEASE: cpu_rst=1 for exactly RESET_PULSE cycles with cpu_halt=1. Then -> IDLE with cpu_halt=0, cpu_rst=0, busy=0, done=1.
- ERROR: error=1, busy=0, cpu_halt stays 1 so a corrupt program never runs. Leaves only on start (-> LEN, flags cleared).
- Timeout: timer clears on entry to LEN and on every accept. It increments each LEN/DATA/CHECK cycle without an accept. Reaching TIMEOUT_CYCLES -> ERROR, code 11. An accept in the same cycle the limit is reached wins.
- mar_load and ram_write are never high together and never high outside ADDR/WRITE.

Test Plan:
- Load L=3 bytes 0x1E,0x2F,0xE0 with checksum 0x2D, in_valid always high -> mar_load/ram_write at addresses 0,1,2 with matching ram_data; cpu_rst high 4 cycles; then done=1, cpu_halt=0, busy=0.
- Length 0x00, and separately length 0x11 -> error=1, error_code=01, no ram_write, cpu_halt stays 1.
- L=2 data 0x10,0x20, checksum 0x31 -> both writes occur, then error_code=10, no cpu_rst pulse.
- TIMEOUT_CYCLES=8: start, send length 0x04, then in_valid low -> error_code=11 after 8 idle cycles. in_valid with gaps of 7 cycles -> completes normally.
- L=16 full memory with random bytes and in_valid toggling -> 16 writes at addresses 0..15, none dropped or duplicated; start pulses while busy ignored.
- Assert rst during WRITE of byte 2 -> all outputs 0 asynchronously. A new start then performs a clean full load.
